// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode VGA test-pattern generator, 2-cycle pipeline.
// Define VGA_PATTERN_BOX_EN to build the animated bouncing box (mode 4).
module vga_pattern_gen #(
  parameter int COLOR_W    = 10,
  parameter int COORD_W    = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 4
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_N,
  input  logic [COORD_W-1:0] iVGA_X,
  input  logic [COORD_W-1:0] iVGA_Y,
  input  logic [2:0]         iMode,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic               oFrame_Start
);

  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [COLOR_W-1:0] MID =
    COLOR_W'(1) << (COLOR_W - 1);
  localparam logic [COORD_W:0] H_LIM = (COORD_W + 1)'(H_ACTIVE);
  localparam logic [COORD_W:0] V_LIM = (COORD_W + 1)'(V_ACTIVE);
  localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_ACTIVE / 8);
  localparam logic [COORD_W-1:0] BAR_MAX = COORD_W'(7);

  logic [2*COORD_W-1:0] prev_xy;
  logic                 fs;
  logic [COORD_W-1:0]   x_q;
  logic [COORD_W-1:0]   y_q;
  logic                 fs_q;
  logic [2:0]           mode_q;
  logic                 in_box;

  assign fs = (iVGA_X == '0) && (iVGA_Y == '0) && (prev_xy != '0);

  // Stage 1: register coordinates, detect frame start, latch mode
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prev_xy <= '1;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      mode_q  <= 3'd0;
    end else begin
      prev_xy <= {iVGA_X, iVGA_Y};
      x_q     <= iVGA_X;
      y_q     <= iVGA_Y;
      fs_q    <= fs;
      if (fs) mode_q <= iMode;
    end
  end

`ifdef VGA_PATTERN_BOX_EN
  localparam logic [COORD_W:0] STEP = (COORD_W + 1)'(BOX_STEP);
  localparam logic [COORD_W:0] SIZE = (COORD_W + 1)'(BOX_SIZE);
  localparam logic [COORD_W:0] X_MAX =
    (COORD_W + 1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0] Y_MAX =
    (COORD_W + 1)'(V_ACTIVE - BOX_SIZE);

  logic [COORD_W-1:0] box_x;
  logic [COORD_W-1:0] box_y;
  logic               dx_left;
  logic               dy_up;
  logic [COORD_W:0]   bx_w;
  logic [COORD_W:0]   by_w;

  assign bx_w = {1'b0, box_x};
  assign by_w = {1'b0, box_y};

  // Box moves one step per frame and bounces off the active edges
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      box_x   <= '0;
      box_y   <= '0;
      dx_left <= 1'b0;
      dy_up   <= 1'b0;
    end else if (fs) begin
      if (!dx_left) begin
        if (bx_w + STEP >= X_MAX) begin
          box_x   <= X_MAX[COORD_W-1:0];
          dx_left <= 1'b1;
        end else begin
          box_x <= box_x + STEP[COORD_W-1:0];
        end
      end else if (bx_w <= STEP) begin
        box_x   <= '0;
        dx_left <= 1'b0;
      end else begin
        box_x <= box_x - STEP[COORD_W-1:0];
      end
      if (!dy_up) begin
        if (by_w + STEP >= Y_MAX) begin
          box_y <= Y_MAX[COORD_W-1:0];
          dy_up <= 1'b1;
        end else begin
          box_y <= box_y + STEP[COORD_W-1:0];
        end
      end else if (by_w <= STEP) begin
        box_y <= '0;
        dy_up <= 1'b0;
      end else begin
        box_y <= box_y - STEP[COORD_W-1:0];
      end
    end
  end

  assign in_box = ({1'b0, x_q} >= bx_w) &&
                  ({1'b0, x_q} < bx_w + SIZE) &&
                  ({1'b0, y_q} >= by_w) &&
                  ({1'b0, y_q} < by_w + SIZE);
`else
  logic unused_box;
  assign unused_box = ^{BOX_SIZE, BOX_STEP};
  assign in_box = 1'b0;
`endif

  logic [COORD_W-1:0] bar_q;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_b;
  logic [COLOR_W-1:0] ramp;
  logic               active;

  assign bar_q   = x_q / BAR_W;
  assign bar_idx = (bar_q > BAR_MAX) ? 3'd7 : bar_q[2:0];
  assign bar_b   = 3'd7 - bar_idx;
  assign active  = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);

  generate
    if (COLOR_W >= COORD_W) begin : g_ramp_pad
      assign ramp = COLOR_W'(x_q) << (COLOR_W - COORD_W);
    end else begin : g_ramp_top
      assign ramp = x_q[COORD_W-1 -: COLOR_W];
    end
  endgenerate

  logic [COLOR_W-1:0] r_d;
  logic [COLOR_W-1:0] g_d;
  logic [COLOR_W-1:0] b_d;

  // Stage 2 colour selection; anything off-screen is black
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      case (mode_q)
        3'd0: b_d = MID;
        3'd1: begin
          r_d = {COLOR_W{bar_b[2]}};
          g_d = {COLOR_W{bar_b[1]}};
          b_d = {COLOR_W{bar_b[0]}};
        end
        3'd2: begin
          if (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) begin
            r_d = FULL;
            g_d = FULL;
            b_d = FULL;
          end
        end
        3'd3: begin
          r_d = ramp;
          g_d = ramp;
          b_d = ramp;
        end
        3'd4: begin
          if (in_box) begin
            r_d = FULL;
            g_d = FULL;
            b_d = FULL;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 2 output registers
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRed         <= '0;
      oGreen       <= '0;
      oBlue        <= '0;
      oFrame_Start <= 1'b0;
    end else begin
      oRed         <= r_d;
      oGreen       <= g_d;
      oBlue        <= b_d;
      oFrame_Start <= fs_q;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen.
// Box expectations follow VGA_PATTERN_BOX_EN like the design.
module tb_vga_pattern_gen;
  localparam int CW = 10;
  localparam int XW = 10;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BS = 32;
  localparam int ST = 4;
  localparam int FULLV = 1023;
  localparam int MIDV  = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] vx = '0;
  logic [XW-1:0] vy = '0;
  logic [2:0]    mode_in = 3'd0;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;
  logic          fso;

  vga_pattern_gen dut (
    .iVGA_CLK    (clk),
    .iRST_N      (rst_n),
    .iVGA_X      (vx),
    .iVGA_Y      (vy),
    .iMode       (mode_in),
    .oRed        (r),
    .oGreen      (g),
    .oBlue       (b),
    .oFrame_Start(fso)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          chk;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          fs;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;
  int m_mode = 0;
  int m_px   = -1;
  int m_py   = -1;
  int bx = 0;
  int by = 0;
  bit dl = 1'b0;
  bit du = 1'b0;

  task automatic model_reset();
    m_mode = 0;
    m_px = -1;
    m_py = -1;
    bx = 0;
    by = 0;
    dl = 1'b0;
    du = 1'b0;
    q.delete();
  endtask

  task automatic box_adv();
    if (!dl) begin
      if (bx + ST >= H - BS) begin bx = H - BS; dl = 1'b1; end
      else bx = bx + ST;
    end else begin
      if (bx <= ST) begin bx = 0; dl = 1'b0; end
      else bx = bx - ST;
    end
    if (!du) begin
      if (by + ST >= V - BS) begin by = V - BS; du = 1'b1; end
      else by = by + ST;
    end else begin
      if (by <= ST) begin by = 0; du = 1'b0; end
      else by = by - ST;
    end
  endtask

  task automatic step(input int x, input int y, input bit chk);
    exp_t e;
    bit   f;
    int   rv, gv, bv, bar, bb;
    @(negedge clk);
    vx = XW'(x);
    vy = XW'(y);
    f = (x == 0 && y == 0) && !(m_px == 0 && m_py == 0);
    if (f) begin
      m_mode = int'(mode_in);
      box_adv();
    end
    m_px = x;
    m_py = y;
    rv = 0; gv = 0; bv = 0;
    if (x < H && y < V) begin
      case (m_mode)
        0: bv = MIDV;
        1: begin
          bar = x / (H / 8);
          if (bar > 7) bar = 7;
          bb = 7 - bar;
          rv = ((bb >> 2) & 1) ? FULLV : 0;
          gv = ((bb >> 1) & 1) ? FULLV : 0;
          bv = (bb & 1) ? FULLV : 0;
        end
        2: if ((((x >> 5) ^ (y >> 5)) & 1) == 1) begin
          rv = FULLV; gv = FULLV; bv = FULLV;
        end
        3: begin rv = x; gv = x; bv = x; end
`ifdef VGA_PATTERN_BOX_EN
        4: if (x >= bx && x < bx + BS && y >= by && y < by + BS) begin
          rv = FULLV; gv = FULLV; bv = FULLV;
        end
`endif
        default: ;
      endcase
    end
    e.chk = chk;
    e.r = CW'(rv);
    e.g = CW'(gv);
    e.b = CW'(bv);
    e.fs = f;
    e.x = XW'(x);
    e.y = XW'(y);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      if (e.chk) begin
        total++;
        if ({r, g, b, fso} !== {e.r, e.g, e.b, e.fs})
          $display("FAIL pix(%0d,%0d) got rgb=%0d,%0d,%0d fs=%0b exp rgb=%0d,%0d,%0d fs=%0b",
                   e.x, e.y, r, g, b, fso, e.r, e.g, e.b, e.fs);
        else passed++;
      end
    end
  endtask

  task automatic flush();
    step(1, 0, 1'b0);
    step(2, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vx = XW'(i * 7);
      vy = XW'(i);
      mode_in = 3'(i);
      @(posedge clk);
      #1;
      total++;
      if ({r, g, b, fso} !== '0)
        $display("FAIL reset_out%0d got %0h exp 0", i, {r, g, b, fso});
      else passed++;
    end
    mode_in = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_solid();
    mode_in = 3'd0;
    step(0, 0, 1'b1);
    for (int y = 0; y < V; y += 53)
      for (int x = 0; x < H; x += 37) step(x, y, 1'b1);
    step(639, 479, 1'b1);
    step(640, 0, 1'b1);
    step(0, 480, 1'b1);
    flush();
  endtask

  task automatic test_bars();
    mode_in = 3'd1;
    step(0, 0, 1'b1);
    for (int x = 1; x < H; x++) step(x, 0, 1'b1);
    step(700, 0, 1'b1);
    flush();
  endtask

  task automatic test_checker();
    mode_in = 3'd2;
    step(0, 0, 1'b1);
    step(32, 0, 1'b1);
    step(32, 32, 1'b1);
    step(31, 0, 1'b1);
    step(0, 32, 1'b1);
    step(64, 96, 1'b1);
    step(700, 0, 1'b1);
    step(639, 479, 1'b1);
    flush();
  endtask

  task automatic test_ramp();
    mode_in = 3'd3;
    step(0, 0, 1'b1);
    step(5, 0, 1'b1);
    step(639, 0, 1'b1);
    for (int x = 0; x < H; x += 13) step(x, 200, 1'b1);
    step(640, 10, 1'b1);
    flush();
  endtask

  task automatic test_mode_change();
    mode_in = 3'd0;
    step(0, 0, 1'b1);
    step(50, 50, 1'b1);
    mode_in = 3'd2;
    step(100, 100, 1'b1);
    step(101, 100, 1'b1);
    step(32, 0, 1'b1);
    step(200, 300, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);
    step(32, 0, 1'b1);
    mode_in = 3'd5;
    step(32, 32, 1'b1);
    step(64, 0, 1'b1);
    step(0, 0, 1'b1);
    step(32, 0, 1'b1);
    step(300, 200, 1'b1);
    flush();
  endtask

  task automatic test_box();
    int px[7];
    int py[7];
    mode_in = 3'd4;
    for (int f = 1; f <= 160; f++) begin
      step(0, 0, 1'b1);
      px[0] = bx;      py[0] = by;
      px[1] = bx + 31; py[1] = by + 31;
      px[2] = bx + 32; py[2] = by;
      px[3] = bx;      py[3] = by + 32;
      px[4] = bx - 1;  py[4] = by;
      px[5] = bx + 31; py[5] = by - 1;
      px[6] = bx + 16; py[6] = by + 16;
      for (int k = 0; k < 7; k++)
        if (px[k] >= 0 && py[k] >= 0 && !(px[k] == 0 && py[k] == 0))
          step(px[k], py[k], 1'b1);
    end
    flush();
  endtask

  task automatic test_reset_midframe();
    mode_in = 3'd2;
    step(0, 0, 1'b1);
    step(32, 0, 1'b1);
    step(40, 5, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({r, g, b, fso} !== '0)
      $display("FAIL async_reset got %0h exp 0", {r, g, b, fso});
    else passed++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(5, 5, 1'b0);
    step(32, 0, 1'b1);
    step(100, 40, 1'b1);
    step(0, 0, 1'b1);
    step(32, 0, 1'b1);
    flush();
  endtask

  initial begin
    test_reset();
    test_solid();
    test_bars();
    test_checker();
    test_ramp();
    test_mode_change();
    test_box();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
